// File: rtl/stopwatch_timebase.sv
// stopwatch_timebase
//   Timebase for the stopwatch display path. Takes the control FSM's mode
//   levels, runs a fractional prescaler (step 1 or 10 per clock against
//   TICK_DIV) and advances a packed BCD elapsed-time counter on each base tick.
//
//   State table:
//     state    | meaning
//     ST_CLR   | prescaler and digits forced to zero
//     ST_RUN1  | counting, prescaler step 1
//     ST_RUN10 | counting, prescaler step 10
//     ST_HOLD  | prescaler and digits frozen
//
//   Ports:
//     clk        system clock
//     rst        synchronous active-high reset
//     run_1x     count at base rate (level)
//     run_10x    count at ten times base rate (level)
//     pause_cmd  hold count and prescaler (level)
//     clear_cmd  zero count and prescaler (level)
//     digits     packed BCD, digit 0 in [3:0]
//     tick       one-cycle pulse on every digits increment
//     ovf        one-cycle pulse when digits wraps all-9s -> all-0s
//     running    registered state is ST_RUN1 or ST_RUN10
//
//   Optional (macro STOPWATCH_LAP_EN):
//     lap_cmd    rising edge while running captures the updated digits
//     lap_digits captured lap time
//     lap_valid  a lap has been captured since the last clear/reset

module stopwatch_timebase #(
    parameter int TICK_DIV = 100000,
    parameter int DIGITS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_1x,
    input  logic                  run_10x,
    input  logic                  pause_cmd,
    input  logic                  clear_cmd,
`ifdef STOPWATCH_LAP_EN
    input  logic                  lap_cmd,
    output logic [4*DIGITS-1:0]   lap_digits,
    output logic                  lap_valid,
`endif
    output logic [4*DIGITS-1:0]   digits,
    output logic                  tick,
    output logic                  ovf,
    output logic                  running
);

    localparam int PW = $clog2(TICK_DIV + 10);

    localparam logic [1:0] ST_CLR   = 2'd0;
    localparam logic [1:0] ST_RUN1  = 2'd1;
    localparam logic [1:0] ST_RUN10 = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [PW-1:0] DIV = PW'(TICK_DIV);

    logic [1:0]          state;
    logic [1:0]          mode;
    logic [PW-1:0]       pres;
    logic [PW-1:0]       pres_sum;
    logic [PW-1:0]       pres_next;
    logic [4*DIGITS-1:0] digits_inc;
    logic [4*DIGITS-1:0] digits_next;
    logic                inc_carry;
    logic                tick_next;
    logic                ovf_next;

    // Mode decode: clear > pause > 10x > 1x, otherwise hold.
    always_comb begin
        mode = ST_HOLD;
        if (clear_cmd)
            mode = ST_CLR;
        else if (pause_cmd)
            mode = ST_HOLD;
        else if (run_10x)
            mode = ST_RUN10;
        else if (run_1x)
            mode = ST_RUN1;
    end

    // Ripple BCD increment; carry left over after the top digit means all-9s.
    always_comb begin
        digits_inc = digits;
        inc_carry  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_carry) begin
                if (digits[4*i +: 4] == 4'd9) begin
                    digits_inc[4*i +: 4] = 4'd0;
                end else begin
                    digits_inc[4*i +: 4] = digits[4*i +: 4] + 4'd1;
                    inc_carry            = 1'b0;
                end
            end
        end
    end

    // pres < TICK_DIV always holds, so pres + 10 fits in PW bits.
    always_comb begin
        pres_sum    = pres + ((mode == ST_RUN10) ? PW'(10) : PW'(1));
        pres_next   = pres;
        digits_next = digits;
        tick_next   = 1'b0;
        ovf_next    = 1'b0;
        case (mode)
            ST_CLR: begin
                pres_next   = '0;
                digits_next = '0;
            end
            ST_RUN1, ST_RUN10: begin
                if (pres_sum >= DIV) begin
                    pres_next   = pres_sum - DIV;
                    digits_next = digits_inc;
                    tick_next   = 1'b1;
                    ovf_next    = inc_carry;
                end else begin
                    pres_next   = pres_sum;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_CLR;
            pres   <= '0;
            digits <= '0;
            tick   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= mode;
            pres   <= pres_next;
            digits <= digits_next;
            tick   <= tick_next;
            ovf    <= ovf_next;
        end
    end

    assign running = (state == ST_RUN1) || (state == ST_RUN10);

`ifdef STOPWATCH_LAP_EN
    logic lap_q;

    // Capture uses the post-update digits so the lap value matches the display
    // on the cycle lap_valid is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q      <= 1'b0;
            lap_digits <= '0;
            lap_valid  <= 1'b0;
        end else begin
            lap_q <= lap_cmd;
            if (mode == ST_CLR) begin
                lap_digits <= '0;
                lap_valid  <= 1'b0;
            end else if (lap_cmd && !lap_q && running) begin
                lap_digits <= digits_next;
                lap_valid  <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_timebase.sv
module tb_stopwatch_timebase;

    localparam int TD   = 20;
    localparam int ND   = 2;
    localparam int PW   = $clog2(TD + 10);
    localparam int MAXC = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run_1x = 1'b0, run_10x = 1'b0, pause_cmd = 1'b0, clear_cmd = 1'b0;
    logic [4*ND-1:0] digits;
    logic tick, ovf, running;

    stopwatch_timebase #(.TICK_DIV(TD), .DIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .run_1x    (run_1x),
        .run_10x   (run_10x),
        .pause_cmd (pause_cmd),
        .clear_cmd (clear_cmd),
        .digits    (digits),
        .tick      (tick),
        .ovf       (ovf),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4*ND-1:0] d;
        logic            t;
        logic            o;
        logic            r;
        logic [PW-1:0]   p;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model: elapsed count as an integer, prescaler as an integer.
    int m_pres  = 0;
    int m_count = 0;
    bit m_tick  = 0;
    bit m_ovf   = 0;
    bit m_run   = 0;

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic drive(input bit r, input bit r1, input bit r10, input bit p, input bit c);
        int   step;
        exp_t e;
        @(negedge clk);
        rst = r; run_1x = r1; run_10x = r10; pause_cmd = p; clear_cmd = c;
        m_tick = 0;
        m_ovf  = 0;
        if (r || c) begin
            m_pres = 0; m_count = 0; m_run = 0;
        end else if (p || (!r10 && !r1)) begin
            m_run = 0;
        end else begin
            m_run = 1;
            step  = r10 ? 10 : 1;
            if (m_pres + step >= TD) begin
                m_pres  = m_pres + step - TD;
                m_count = (m_count + 1) % MAXC;
                m_tick  = 1;
                m_ovf   = (m_count == 0);
            end else begin
                m_pres = m_pres + step;
            end
        end
        e.d = to_bcd(m_count);
        e.t = m_tick;
        e.o = m_ovf;
        e.r = m_run;
        e.p = PW'(m_pres);
        q.push_back(e);
    endtask

    task automatic repeat_drive(input int n, input bit r1, input bit r10, input bit p, input bit c);
        for (int i = 0; i < n; i++) drive(0, r1, r10, p, c);
    endtask

    // Fixed-value checkpoint straight from the test plan, independent of the model.
    task automatic check_now(input string name, input logic [4*ND-1:0] wd, input int wp,
                             input bit wt, input bit wo, input bit wr);
        @(posedge clk);
        #2;
        total++;
        if (digits !== wd || dut.pres !== PW'(wp) || tick !== wt || ovf !== wo || running !== wr) begin
            bad++;
            $display("FAIL %s: got digits=%h pres=%0d tick=%b ovf=%b running=%b, want digits=%h pres=%0d tick=%b ovf=%b running=%b",
                     name, digits, dut.pres, tick, ovf, running, wd, wp, wt, wo, wr);
        end
    endtask

    // Monitor: every clock the DUT presents a new registered output word.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                total++;
                if (digits !== e.d || tick !== e.t || ovf !== e.o || running !== e.r || dut.pres !== e.p) begin
                    bad++;
                    $display("FAIL cycle t=%0t: got digits=%h tick=%b ovf=%b running=%b pres=%0d, want digits=%h tick=%b ovf=%b running=%b pres=%0d",
                             $time, digits, tick, ovf, running, dut.pres, e.d, e.t, e.o, e.r, e.p);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two cycles with run_1x asserted.
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        check_now("reset", 8'h00, 0, 0, 0, 0);

        // 40 edges at 1x: ticks on edges 20 and 40.
        repeat_drive(40, 1, 0, 0, 0);
        check_now("run1x_40", 8'h02, 0, 1, 0, 1);

        // 10x from clear: 99 after edge 198, wrap with ovf on edge 200.
        drive(0, 0, 0, 0, 1);
        repeat_drive(198, 0, 1, 0, 0);
        check_now("run10x_198", 8'h99, 0, 1, 0, 1);
        repeat_drive(2, 0, 1, 0, 0);
        check_now("run10x_wrap", 8'h00, 0, 1, 1, 1);

        // Remainder carries across a 1x -> 10x switch.
        drive(0, 0, 0, 0, 1);
        repeat_drive(15, 1, 0, 0, 0);
        repeat_drive(1, 0, 1, 0, 0);
        check_now("switch_1x_10x", 8'h01, 5, 1, 0, 1);

        // Pause freezes digits and prescaler.
        drive(0, 0, 0, 0, 1);
        repeat_drive(25, 1, 0, 0, 0);
        repeat_drive(10, 1, 0, 1, 0);
        check_now("pause_hold", 8'h01, 5, 0, 0, 0);
        repeat_drive(15, 1, 0, 0, 0);
        check_now("pause_resume", 8'h02, 0, 1, 0, 1);

        // Clear beats a simultaneous run_10x.
        drive(0, 0, 0, 0, 1);
        repeat_drive(74, 0, 1, 0, 0);
        check_now("reach_37", 8'h37, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 1);
        check_now("clear_priority", 8'h00, 0, 0, 0, 0);

        // Randomized mode mix, including 1-cycle mode changes and mid-count reset.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 1) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 49) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
